// File: rtl/serial_subtractor_n.sv
// Digit-serial subtractor: a - b - b_in computed W bits per cycle as a + ~b + ~b_in.
// Optional signed-overflow flag output ovf is built only when SUB_OVERFLOW_EN is defined.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | one W-bit digit per cycle, LSB digit first
// DONE  | result presented, out_valid=1 until out_ready
module serial_subtractor_n #(
  parameter int N = 32,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         b_in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] diff,
  output logic         b_out,
  output logic         out_valid,
`ifdef SUB_OVERFLOW_EN
  output logic         ovf,
`endif
  input  logic         out_ready
);

  if ((W < 1) || (W > N) || ((N % W) != 0)) begin : g_param_chk
    $error("serial_subtractor_n: W must divide N and satisfy 1 <= W <= N");
  end

  localparam int DIGITS = N / W;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [N-1:0]   r_a;
  logic [N-1:0]   r_nb;
  logic [N-1:0]   r_acc;
  logic [N-1:0]   r_diff;
  logic           r_b_out;
  logic           r_carry;
  logic [CW-1:0]  r_cnt;
  logic [W:0]     w_sum;
  logic [N-1:0]   w_acc_nxt;
  logic           w_last;

  assign w_sum     = {1'b0, r_a[W-1:0]} + {1'b0, r_nb[W-1:0]} + {{W{1'b0}}, r_carry};
  // new digit enters at the top so the last digit leaves the word fully aligned
  assign w_acc_nxt = (r_acc >> W) | (N'(w_sum[W-1:0]) << (N - W));
  assign w_last    = (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_a     <= '0;
      r_nb    <= '0;
      r_acc   <= '0;
      r_diff  <= '0;
      r_b_out <= 1'b0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_nb    <= ~b;
            r_carry <= ~b_in;
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          r_a     <= r_a >> W;
          r_nb    <= r_nb >> W;
          r_acc   <= w_acc_nxt;
          r_carry <= w_sum[W];
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_diff  <= w_acc_nxt;
            r_b_out <= ~w_sum[W];
          end
        end
        default: ;
      endcase
    end
  end

  assign diff  = r_diff;
  assign b_out = r_b_out;

`ifdef SUB_OVERFLOW_EN
  logic r_a_msb;
  logic r_b_msb;
  logic r_ovf;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (r_state == S_IDLE && in_valid) begin
      r_a_msb <= a[N-1];
      r_b_msb <= b[N-1];
    end else if (r_state == S_RUN && w_last) begin
      r_ovf <= (r_a_msb != r_b_msb) && (w_acc_nxt[N-1] != r_a_msb);
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor_n.sv
// Self-checking bench for serial_subtractor_n: directed cases plus random operations
// against an arithmetic reference, on W=4, W=1 and W=32 instances (N=32).
module tb_serial_subtractor_n;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ta, tbv;
  logic        tbin;
  logic        iv   [3];
  logic        orr  [3];
  logic        ir   [3];
  logic [31:0] dif  [3];
  logic        bo   [3];
  logic        ovv  [3];
`ifdef SUB_OVERFLOW_EN
  logic        ovf  [3];
`endif
  int          n_tests = 0;
  int          n_fail  = 0;
  int          lat_exp [3] = '{8, 32, 1};

  always #5 clk = ~clk;

  serial_subtractor_n #(.N(32), .W(4)) u_w4 (
    .clk(clk), .rst(rst), .a(ta), .b(tbv), .b_in(tbin), .in_valid(iv[0]), .in_ready(ir[0]),
    .diff(dif[0]), .b_out(bo[0]), .out_valid(ovv[0]),
`ifdef SUB_OVERFLOW_EN
    .ovf(ovf[0]),
`endif
    .out_ready(orr[0]));

  serial_subtractor_n #(.N(32), .W(1)) u_w1 (
    .clk(clk), .rst(rst), .a(ta), .b(tbv), .b_in(tbin), .in_valid(iv[1]), .in_ready(ir[1]),
    .diff(dif[1]), .b_out(bo[1]), .out_valid(ovv[1]),
`ifdef SUB_OVERFLOW_EN
    .ovf(ovf[1]),
`endif
    .out_ready(orr[1]));

  serial_subtractor_n #(.N(32), .W(32)) u_w32 (
    .clk(clk), .rst(rst), .a(ta), .b(tbv), .b_in(tbin), .in_valid(iv[2]), .in_ready(ir[2]),
    .diff(dif[2]), .b_out(bo[2]), .out_valid(ovv[2]),
`ifdef SUB_OVERFLOW_EN
    .ovf(ovf[2]),
`endif
    .out_ready(orr[2]));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void ref_sub(input logic [31:0] a, input logic [31:0] b, input logic bin,
                                  output logic [31:0] d, output logic bout, output logic ov);
    logic [32:0] full;
    longint      s;
    full = {1'b0, a} - {1'b0, b} - 33'(bin);
    d    = full[31:0];
    bout = ({1'b0, a} < ({1'b0, b} + 33'(bin)));
    s    = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
    ov   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  task automatic start_op(input int k, input logic [31:0] a, input logic [31:0] b, input logic bin);
    int g = 0;
    while (!ir[k] && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 200) check("in_ready_timeout", 64'(ir[k]), 64'd1);
    ta = a; tbv = b; tbin = bin;
    iv[k] = 1'b1;
    @(posedge clk); #1;
    iv[k] = 1'b0;
  endtask

  task automatic wait_result(input int k, output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ovv[k] && lat < 200);
  endtask

  task automatic run_check(input int k, input logic [31:0] a, input logic [31:0] b,
                           input logic bin, input int hold, input string tag);
    logic [31:0] ed;
    logic        eb, eo;
    int          lat;
    ref_sub(a, b, bin, ed, eb, eo);
    start_op(k, a, b, bin);
    wait_result(k, lat);
    check({tag, "_latency"}, 64'(lat), 64'(lat_exp[k]));
    for (int i = 0; i < hold; i++) begin
      ta = $urandom; tbv = $urandom;
      @(posedge clk); #1;
    end
    check({tag, "_diff"}, 64'(dif[k]), 64'(ed));
    check({tag, "_b_out"}, 64'(bo[k]), 64'(eb));
`ifdef SUB_OVERFLOW_EN
    check({tag, "_ovf"}, 64'(ovf[k]), 64'(eo));
`endif
    orr[k] = 1'b1;
    @(posedge clk); #1;
    orr[k] = 1'b0;
    check({tag, "_ready_after"}, {62'd0, ir[k], ovv[k]}, 64'b10);
  endtask

  initial begin
    logic [31:0] hd;
    logic        hb;
    int          lat;
    logic [31:0] ra, rb;

    rst = 1'b0; ta = '0; tbv = '0; tbin = 1'b0;
    for (int k = 0; k < 3; k++) begin iv[k] = 1'b0; orr[k] = 1'b0; end
    @(posedge clk); #1;
    check("reset_state", {29'd0, ir[0], ovv[0], bo[0], dif[0]}, {29'd0, 3'b100, 32'd0});
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_reset", 64'(ir[0]), 64'd1);

    run_check(0, 32'hA0040002, 32'hD0040004, 1'b1, 0, "ex_w4");
    check("ex_w4_value", 64'(dif[0]), 64'hCFFFFFFD);
    run_check(1, 32'hA0040002, 32'hD0040004, 1'b1, 0, "ex_w1");
    check("ex_w1_value", {31'd0, bo[1], dif[1]}, {31'd0, 1'b1, 32'hCFFFFFFD});
    run_check(2, 32'hA0040002, 32'hD0040004, 1'b1, 0, "ex_w32");
    check("ex_w32_value", {31'd0, bo[2], dif[2]}, {31'd0, 1'b1, 32'hCFFFFFFD});

    run_check(0, 32'h0, 32'h0, 1'b1, 0, "zero_bin");
    check("zero_bin_value", 64'(dif[0]), 64'hFFFFFFFF);
    run_check(0, 32'h80000000, 32'h1, 1'b0, 1, "min_minus_one");
    check("min_minus_one_value", {31'd0, bo[0], dif[0]}, {31'd0, 1'b0, 32'h7FFFFFFF});

    // result must stay frozen while the consumer stalls
    start_op(0, 32'h12345678, 32'h9ABCDEF0, 1'b0);
    wait_result(0, lat);
    check("hold_latency", 64'(lat), 64'd8);
    hd = dif[0]; hb = bo[0];
    check("hold_first", {31'd0, hb, hd}, {31'd0, 1'b1, 32'h77777788});
    for (int i = 0; i < 5; i++) begin
      iv[0] = ~iv[0]; ta = $urandom; tbv = $urandom; tbin = ~tbin;
      @(posedge clk); #1;
      check("hold_stable", {29'd0, ir[0], ovv[0], bo[0], dif[0]}, {29'd0, 2'b01, hb, hd});
    end
    iv[0] = 1'b0;
    orr[0] = 1'b1;
    @(posedge clk); #1;
    orr[0] = 1'b0;
    check("hold_release", {62'd0, ir[0], ovv[0]}, 64'b10);

    // abort during RUN
    start_op(0, 32'hFFFF0000, 32'h0000FFFF, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("abort_state", {30'd0, ir[0], ovv[0], dif[0]}, {30'd0, 2'b10, 32'd0});
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check("abort_no_result", {62'd0, ir[0], ovv[0]}, 64'b10);
    end
    run_check(0, 32'd5, 32'd3, 1'b0, 0, "after_abort");
    check("after_abort_value", {31'd0, bo[0], dif[0]}, {31'd0, 1'b0, 32'd2});

    for (int n = 0; n < 1000; n++) begin
      ra = $urandom; rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = ra;
        1: ra = 32'h0;
        2: rb = 32'hFFFFFFFF;
        3: begin ra = 32'h80000000; rb = $urandom_range(0, 3); end
        4: rb = ra + 32'd1;
        default: ;
      endcase
      run_check(0, ra, rb, 1'($urandom), $urandom_range(0, 2), "rand_w4");
    end
    for (int n = 0; n < 10; n++)
      run_check(1, $urandom, $urandom, 1'($urandom), 0, "rand_w1");
    for (int n = 0; n < 20; n++)
      run_check(2, $urandom, $urandom, 1'($urandom), $urandom_range(0, 1), "rand_w32");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_subtractor_n.md
SERIAL_SUBTRACTOR_N -- requirements
Module: serial_subtractor_n

Interface
REQ-001 Parameter N, default 32: operand width in bits.
REQ-002 Parameter W, default 4: digit width in bits processed per cycle; N % W == 0 and 1 <= W <= N, otherwise elaboration SHALL fail.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 a  input  N  minuend.
REQ-006 b  input  N  subtrahend.
REQ-007 b_in  input  1  borrow-in, subtracted from the LSB.
REQ-008 in_valid  input  1  operands a, b, b_in are valid.
REQ-009 in_ready  output  1  block accepts operands.
REQ-010 diff  output  N  result, a - b - b_in mod 2^N.
REQ-011 b_out  output  1  borrow-out, 1 iff a < b + b_in as unsigned values.
REQ-012 out_valid  output  1  diff and b_out are valid.
REQ-013 out_ready  input  1  consumer accepts the result.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DONE; IDLE is the reset state.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 IDLE: on in_valid=1, the block SHALL latch a, ~b and b_in into internal shift registers, clear the digit counter and go to RUN.
REQ-017 RUN: each cycle, the block SHALL compute one W-bit digit, LSB digit first, as a_digit + ~b_digit + carry.
REQ-018 The initial carry SHALL be ~b_in; the carry-out SHALL be registered for the next digit.
REQ-019 RUN SHALL last exactly N/W cycles; after the last digit the FSM SHALL go to DONE.
REQ-020 Latency: if the input transfer happens at edge t, out_valid SHALL first be 1 after edge t+N/W.
REQ-021 b_out SHALL equal the inverse of the final carry.
REQ-022 diff and b_out SHALL stay stable while out_valid=1 and out_ready=0.
REQ-023 DONE: on out_ready=1, the FSM SHALL go to IDLE at that edge; in_ready SHALL be 1 in the following cycle. There is no same-cycle bypass from output to input.
REQ-024 in_valid and operand changes outside IDLE SHALL be ignored.
REQ-025 out_ready outside DONE SHALL be ignored.
REQ-026 diff SHALL hold its last value in IDLE and RUN until the next result is written.
REQ-027 W = N SHALL be legal: the block then computes in a single RUN cycle.
REQ-028 Internal adders SHALL be W+1 bits wide; no N-bit adder SHALL be instantiated.

Reset
REQ-029 With rst=0 at a clock edge, the block SHALL go to IDLE and set diff=0, b_out=0, out_valid=0, in_ready=1, and clear the counter and carry.
REQ-030 Reset asserted during RUN or DONE SHALL abort the operation; no result is presented afterwards.
REQ-031 in_ready SHALL be 1 in the first cycle after rst returns to 1.

Configuration
REQ-032 Macro SUB_OVERFLOW_EN controls an extra output port ovf (output, 1 bit).
REQ-033 With SUB_OVERFLOW_EN defined, ovf SHALL be 1 iff a - b - b_in, read as a two's-complement difference, overflows N bits, i.e. a[N-1] != b[N-1] and diff[N-1] != a[N-1].
REQ-034 With SUB_OVERFLOW_EN defined, ovf SHALL be valid and stable under the same rules as diff, and SHALL reset to 0.
REQ-035 With SUB_OVERFLOW_EN undefined, the port ovf and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification (N=32, W=4 unless stated)
REQ-036 a=0xA0040002, b=0xD0040004, b_in=1 -> diff=0xCFFFFFFD, b_out=1, ovf=0; out_valid rises exactly 8 edges after the transfer.
REQ-037 a=0, b=0, b_in=1 -> diff=0xFFFFFFFF, b_out=1; a=0x80000000, b=1, b_in=0 -> diff=0x7FFFFFFF, b_out=0, ovf=1.
REQ-038 Hold out_ready=0 for 5 cycles in DONE while toggling in_valid and a/b -> diff, b_out and out_valid unchanged, in_ready=0; on out_ready=1, in_ready=1 on the next cycle.
REQ-039 rst=0 at RUN cycle 3 -> next cycle: IDLE, out_valid=0, diff=0, in_ready=1; a new operation 5-3, b_in=0 -> diff=2, b_out=0.
REQ-040 Repeat REQ-036 with W=1 (32 RUN cycles) and W=32 (1 RUN cycle) -> identical diff and b_out; plus 1000 random back-to-back operations checked against a reference model.
